// File: rtl/vend_pkg.sv
// vend_pkg: shared FSM states, change-coin codes and coin unit values for the vending controller
package vend_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_e;
   typedef enum logic [1:0] {NONE = 2'b00, NICKEL = 2'b01, DIME = 2'b10, QUARTER = 2'b11} coin_e;
   localparam int NICKEL_U  = 1;
   localparam int DIME_U    = 2;
   localparam int QUARTER_U = 5;
endpackage

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy change coin (quarter/dime/nickel) and its unit value for a given credit
//   credit_i : credit remaining, 5-cent units
//   coin_o   : largest coin not exceeding credit_i, NONE when credit_i is 0
//   unit_o   : value of coin_o in 5-cent units
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 4
) (
   input  logic [CREDIT_W-1:0] credit_i,
   output coin_e               coin_o,
   output logic [2:0]          unit_o
);
   always_comb begin
      coin_o = credit_i >= CREDIT_W'(QUARTER_U) ? QUARTER :
               credit_i >= CREDIT_W'(DIME_U)    ? DIME    :
               credit_i != '0                   ? NICKEL  : NONE;
      unit_o = coin_o == QUARTER ? 3'(QUARTER_U) :
               coin_o == DIME    ? 3'(DIME_U)    :
               coin_o == NICKEL  ? 3'(NICKEL_U)  : 3'd0;
   end
endmodule

// File: rtl/vend_credit_ctrl.sv
// vend_credit_ctrl: multi-product vending controller with credit accumulation, vend handshake and greedy change return
//   clk_i, rst_ni                  : clock, async active-low reset
//   nickel_i, dime_i, quarter_i    : one-cycle coin pulses
//   select_i, cancel_i             : one-hot product request, refund request
//   vend_valid_o/vend_sel_o/vend_ready_i : product handshake to dispenser
//   chg_valid_o/chg_coin_o/chg_ready_i   : one-coin-per-handshake change to hopper
//   reject_o                       : registered pulse, last coin not accepted
//   credit_o, busy_o               : credit in 5-cent units, high in VEND or CHANGE
module vend_credit_ctrl
   import vend_pkg::*;
#(
   parameter int  PRICE_UNITS      = 5,
   parameter int  MAX_CREDIT_UNITS = 15,
   parameter int  N_PRODUCTS       = 4,
   localparam int CREDIT_W         = $clog2(MAX_CREDIT_UNITS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  nickel_i,
   input  logic                  dime_i,
   input  logic                  quarter_i,
   input  logic [N_PRODUCTS-1:0] select_i,
   input  logic                  cancel_i,
   output logic                  vend_valid_o,
   output logic [N_PRODUCTS-1:0] vend_sel_o,
   input  logic                  vend_ready_i,
   output logic                  chg_valid_o,
   output logic [1:0]            chg_coin_o,
   input  logic                  chg_ready_i,
   output logic                  reject_o,
   output logic [CREDIT_W-1:0]   credit_o,
   output logic                  busy_o
);
   if (MAX_CREDIT_UNITS < PRICE_UNITS + 4) begin : g_cfg_chk
      $error("vend_credit_ctrl: MAX_CREDIT_UNITS must be >= PRICE_UNITS+4");
   end

   localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_UNITS);
   localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT_UNITS);

   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d, credit_add;
   logic [N_PRODUCTS-1:0] sel_q, sel_d;
   logic                  reject_q, reject_d;
   logic [2:0]            coin_val, chg_unit;
   logic [CREDIT_W:0]     sum;
   logic                  coin_ok, sel_ok;
   coin_e                 chg_coin;

   vend_change_sel #(.CREDIT_W(CREDIT_W)) u_chg_sel (
      .credit_i(credit_q),
      .coin_o  (chg_coin),
      .unit_o  (chg_unit)
   );

   always_comb begin
      coin_val   = nickel_i ? 3'(NICKEL_U) : dime_i ? 3'(DIME_U) : 3'(QUARTER_U);
      sum        = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_val);
      coin_ok    = (state_q == IDLE || state_q == ACCUM) &&
                   $countones({nickel_i, dime_i, quarter_i}) == 1 && sum <= MAX_C;
      credit_add = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
      reject_d   = (nickel_i | dime_i | quarter_i) && !coin_ok;
      // price check uses pre-coin credit; cancel outranks select
      sel_ok     = state_q == ACCUM && !cancel_i && $onehot(select_i) && credit_q >= PRICE_C;
      state_d    = state_q;
      credit_d   = credit_q;
      sel_d      = sel_q;
      case (state_q)
         IDLE: begin
            credit_d = credit_add;
            state_d  = coin_ok ? ACCUM : IDLE;
         end
         ACCUM: begin
            credit_d = credit_add;
            state_d  = cancel_i ? CHANGE : sel_ok ? VEND : ACCUM;
            sel_d    = sel_ok ? select_i : sel_q;
         end
         VEND: if (vend_ready_i) begin
            credit_d = credit_q - PRICE_C;
            state_d  = credit_q == PRICE_C ? IDLE : CHANGE;
         end
         CHANGE: if (chg_ready_i && chg_valid_o) begin
            credit_d = credit_q - CREDIT_W'(chg_unit);
            state_d  = credit_q == CREDIT_W'(chg_unit) ? IDLE : CHANGE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         credit_q <= '0;
         sel_q    <= '0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         sel_q    <= sel_d;
         reject_q <= reject_d;
      end
   end

   assign vend_valid_o = state_q == VEND;
   assign vend_sel_o   = vend_valid_o ? sel_q : '0;
   assign chg_valid_o  = state_q == CHANGE && credit_q != '0;
   assign chg_coin_o   = chg_valid_o ? chg_coin : NONE;
   assign reject_o     = reject_q;
   assign credit_o     = credit_q;
   assign busy_o       = state_q == VEND || state_q == CHANGE;
endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb_vend_credit_ctrl: directed plus randomized check of vend_credit_ctrl against a behavioural model
module tb_vend_credit_ctrl;
   localparam int PRICE = 5;
   localparam int MAXC  = 15;
   localparam int NP    = 4;

   logic          clk_i = 1'b0, rst_ni = 1'b0;
   logic          nickel_i = 0, dime_i = 0, quarter_i = 0, cancel_i = 0;
   logic [NP-1:0] select_i = '0;
   logic          vend_ready_i = 0, chg_ready_i = 0;
   logic          vend_valid_o, chg_valid_o, reject_o, busy_o;
   logic [NP-1:0] vend_sel_o;
   logic [1:0]    chg_coin_o;
   logic [3:0]    credit_o;

   vend_credit_ctrl #(.PRICE_UNITS(PRICE), .MAX_CREDIT_UNITS(MAXC), .N_PRODUCTS(NP)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .nickel_i(nickel_i), .dime_i(dime_i), .quarter_i(quarter_i),
      .select_i(select_i), .cancel_i(cancel_i), .vend_valid_o(vend_valid_o), .vend_sel_o(vend_sel_o),
      .vend_ready_i(vend_ready_i), .chg_valid_o(chg_valid_o), .chg_coin_o(chg_coin_o),
      .chg_ready_i(chg_ready_i), .reject_o(reject_o), .credit_o(credit_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0, bad = 0;
   // model: credit, a pending vend, a refund/change in progress, last-cycle reject
   int m_credit = 0, m_sel = 0;
   bit m_vend = 0, m_chg = 0, m_rej = 0;

   function automatic int greedy(input int c);
      return c >= 5 ? 5 : c >= 2 ? 2 : c >= 1 ? 1 : 0;
   endfunction

   function automatic int coin_code(input int u);
      return u == 5 ? 3 : u == 2 ? 2 : u == 1 ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("vend_valid", int'(vend_valid_o), int'(m_vend));
      chk("vend_sel", int'(vend_sel_o), m_vend ? m_sel : 0);
      chk("chg_valid", int'(chg_valid_o), int'(m_chg));
      chk("chg_coin", int'(chg_coin_o), m_chg ? coin_code(greedy(m_credit)) : 0);
      chk("reject", int'(reject_o), int'(m_rej));
      chk("credit", int'(credit_o), m_credit);
      chk("busy", int'(busy_o), int'(m_vend | m_chg));
   endtask

   task automatic step();
      int ncoin, val, pre;
      bit ok;
      ncoin = int'(nickel_i) + int'(dime_i) + int'(quarter_i);
      val   = nickel_i ? 1 : dime_i ? 2 : 5;
      ok    = !m_vend && !m_chg && ncoin == 1 && m_credit + val <= MAXC;
      m_rej = ncoin > 0 && !ok;
      if (m_vend) begin
         if (vend_ready_i) begin
            m_credit -= PRICE;
            m_vend = 0;
            m_chg  = m_credit > 0;
         end
      end else if (m_chg) begin
         if (chg_ready_i) begin
            m_credit -= greedy(m_credit);
            m_chg = m_credit > 0;
         end
      end else begin
         pre = m_credit;
         if (ok) m_credit += val;
         if (cancel_i && pre > 0) m_chg = 1;
         else if ($countones(select_i) == 1 && pre >= PRICE) begin
            m_vend = 1;
            m_sel  = int'(select_i);
         end
      end
      @(posedge clk_i);
      #1;
      compare_all();
   endtask

   // coins = {quarter, dime, nickel}
   task automatic cyc(input logic [2:0] coins, input logic [NP-1:0] sel, input logic can,
                      input logic vr, input logic cr);
      {quarter_i, dime_i, nickel_i} = coins;
      select_i = sel; cancel_i = can; vend_ready_i = vr; chg_ready_i = cr;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(3'b000, '0, 0, 0, 0);
   endtask

   task automatic do_reset();
      {quarter_i, dime_i, nickel_i} = 3'b000;
      select_i = '0; cancel_i = 0; vend_ready_i = 0; chg_ready_i = 0;
      rst_ni = 0;
      #2;
      m_credit = 0; m_vend = 0; m_chg = 0; m_rej = 0; m_sel = 0;
      compare_all();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1;
   endtask

   initial begin
      do_reset();
      chk("rst_credit_lit", int'(credit_o), 0);
      // quarter, vend exact price, no change
      cyc(3'b100, '0, 0, 0, 0);
      chk("q_credit_lit", int'(credit_o), 5);
      cyc(3'b000, 4'b0001, 0, 0, 0);
      chk("vend_valid_lit", int'(vend_valid_o), 1);
      chk("vend_sel_lit", int'(vend_sel_o), 1);
      cyc(3'b000, '0, 0, 1, 0);
      chk("after_vend_credit_lit", int'(credit_o), 0);
      chk("after_vend_nochg_lit", int'(chg_valid_o), 0);
      // three dimes, vend, nickel change
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      chk("ddd_credit_lit", int'(credit_o), 6);
      cyc(3'b000, 4'b0100, 0, 0, 0);
      cyc(3'b000, '0, 0, 1, 0);
      chk("chg_credit_lit", int'(credit_o), 1);
      chk("chg_nickel_lit", int'(chg_coin_o), 1);
      cyc(3'b000, '0, 0, 0, 1);
      chk("chg_done_lit", int'(busy_o), 0);
      // cancel refund with hopper stall
      cyc(3'b100, '0, 0, 0, 0);
      cyc(3'b100, '0, 0, 0, 0);
      cyc(3'b000, '0, 1, 0, 0);
      chk("refund_q1_lit", int'(chg_coin_o), 3);
      idle(3);
      chk("refund_stall_lit", int'(chg_coin_o), 3);
      chk("refund_stall_credit_lit", int'(credit_o), 10);
      cyc(3'b000, '0, 0, 0, 1);
      chk("refund_q2_credit_lit", int'(credit_o), 5);
      cyc(3'b000, '0, 0, 0, 1);
      chk("refund_done_lit", int'(credit_o), 0);
      // ceiling and multi-coin reject
      cyc(3'b100, '0, 0, 0, 0);
      cyc(3'b100, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b001, '0, 0, 0, 0);
      chk("max_credit_lit", int'(credit_o), 15);
      cyc(3'b010, '0, 0, 0, 0);
      chk("overflow_rej_lit", int'(reject_o), 1);
      chk("overflow_credit_lit", int'(credit_o), 15);
      idle(1);
      cyc(3'b011, '0, 0, 0, 0);
      chk("multi_rej_lit", int'(reject_o), 1);
      cyc(3'b000, '0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(3'b000, '0, 0, 0, 1);
      // underfunded and non-one-hot selects, coin during VEND
      cyc(3'b001, '0, 0, 0, 0);
      cyc(3'b000, 4'b0010, 0, 0, 0);
      chk("underfunded_lit", int'(vend_valid_o), 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b000, 4'b0011, 0, 0, 0);
      chk("not_onehot_lit", int'(vend_valid_o), 0);
      cyc(3'b000, 4'b1000, 0, 0, 0);
      cyc(3'b001, '0, 0, 0, 0);
      chk("vend_coin_rej_lit", int'(reject_o), 1);
      chk("vend_coin_credit_lit", int'(credit_o), 5);
      cyc(3'b000, '0, 0, 1, 0);
      // reset mid-change
      cyc(3'b100, '0, 0, 0, 0);
      cyc(3'b010, '0, 0, 0, 0);
      cyc(3'b000, '0, 1, 0, 0);
      chk("pre_reset_credit_lit", int'(credit_o), 7);
      do_reset();
      chk("reset_chg_lit", int'(chg_valid_o), 0);
      cyc(3'b100, '0, 0, 0, 0);
      chk("post_reset_q_lit", int'(credit_o), 5);
      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         logic [2:0] c;
         c = $urandom_range(0, 3) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
         if ($urandom_range(0, 599) == 0) do_reset();
         cyc(c, $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000,
             $urandom_range(0, 15) == 0, 1'($urandom), 1'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vend_credit_ctrl.md
Name: vend_credit_ctrl

Overview:
Parametrised vending controller, next generation of the single-product nickel/dime/quarter machine. Accumulates credit in 5-cent units and serves N_PRODUCTS selections at a configurable price. Hands the product request to the dispenser over a valid/ready handshake. Returns change or a cancel refund one coin per handshake, using greedy quarter/dime/nickel selection.

Parameters:
PRICE_UNITS, 5, product price in 5-cent units (5 = 25c)
MAX_CREDIT_UNITS, 15, credit ceiling in 5-cent units; must be >= PRICE_UNITS+4 (elaboration assertion)
N_PRODUCTS, 4, number of product channels
CREDIT_W, $clog2(MAX_CREDIT_UNITS+1), credit register width (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
nickel_i  in  1  5c coin pulse, one cycle
dime_i  in  1  10c coin pulse, one cycle
quarter_i  in  1  25c coin pulse, one cycle
select_i  in  N_PRODUCTS  one-hot product request pulse
cancel_i  in  1  refund request pulse
vend_valid_o  out  1  product request valid
vend_sel_o  out  N_PRODUCTS  one-hot product being vended
vend_ready_i  in  1  dispenser accepts product request
chg_valid_o  out  1  change coin valid
chg_coin_o  out  2  01 nickel, 10 dime, 11 quarter, 00 none
chg_ready_i  in  1  coin hopper accepts coin
reject_o  out  1  registered pulse: last coin returned unaccepted
credit_o  out  CREDIT_W  current credit in 5-cent units
busy_o  out  1  high in VEND or CHANGE

Behaviour:
- Reset (async assert, sync release): state IDLE, credit 0, every output 0. A reset during VEND or CHANGE discards the pending vend and change.
- States:
  - IDLE: credit == 0.
  - ACCUM: 0 < credit, with credit possibly >= price.
  - VEND.
  - CHANGE.
- Coins are sampled in IDLE and ACCUM only. Values are 1, 2 and 5 units.
  - A coin is accepted if exactly one coin input is high and credit + value <= MAX_CREDIT_UNITS.
  - An accepted coin updates credit on the next edge. IDLE moves to ACCUM.
  - The coin is rejected (reject_o = 1 in the following cycle, credit unchanged) in any of these cases:
    - more than one coin input is high;
    - the coin would overflow MAX_CREDIT_UNITS;
    - the coin arrives in VEND or CHANGE.
- Select in ACCUM:
  - Acted on only if select_i is one-hot and credit >= PRICE_UNITS. A non-one-hot or underfunded select is ignored with no response.
  - On acceptance: latch vend_sel_o, go to VEND.
  - A coin accepted in the same cycle is still added. The price check uses credit from before that coin.
- Cancel in ACCUM: go to CHANGE with the full credit (refund).
  - Cancel takes priority over select in the same cycle.
  - Cancel in IDLE, VEND or CHANGE is ignored.
- VEND:
  - vend_valid_o = 1, vend_sel_o stable until the cycle where vend_ready_i = 1.
  - On that handshake edge: credit -= PRICE_UNITS. Go to CHANGE if the result is > 0, else IDLE. vend_valid_o drops the next cycle.
- CHANGE:
  - chg_valid_o = 1 while credit > 0.
  - chg_coin_o is the greedy choice from the registered credit: quarter if credit >= 5, else dime if >= 2, else nickel. It is stable while chg_ready_i = 0.
  - Each handshake edge subtracts 5, 2 or 1 from credit.
  - When the subtraction reaches 0, go to IDLE, and chg_valid_o and chg_coin_o are 0 the next cycle.
- chg_coin_o = 00 whenever chg_valid_o = 0.
- credit_o mirrors the credit register. Credit never underflows and never exceeds MAX_CREDIT_UNITS.
- Latencies:
  - coin to credit_o: 1 cycle;
  - select to vend_valid_o: 1 cycle;
  - vend handshake to first chg_valid_o: 1 cycle.

Decomposition:
- vend_pkg holds:
  - state_e (IDLE, ACCUM, VEND, CHANGE);
  - coin_e (NONE = 2'b00, NICKEL = 2'b01, DIME = 2'b10, QUARTER = 2'b11);
  - unit-value constants NICKEL_U = 1, DIME_U = 2, QUARTER_U = 5.
- One sub-module, vend_change_sel: combinational greedy coin choice and its unit value from the credit.

Test Plan:
- Defaults. Quarter in IDLE -> credit_o 5. select_i = 0001 -> vend_valid_o, vend_sel_o = 0001. vend_ready_i -> credit 0, IDLE, no chg_valid_o.
- Dime, dime, dime (credit 6). select 0100, vend_ready_i -> CHANGE with credit 1. chg_coin_o = nickel. chg_ready_i -> credit 0, IDLE.
- Quarter, quarter (credit 10). cancel_i -> chg_coin_o quarter, quarter; credit 10 -> 5 -> 0. Hold chg_ready_i low 3 cycles -> chg_coin_o stable.
- Credit 14 (two quarters, two dimes) then nickel -> credit 15. Then a further dime -> reject_o pulse, credit stays 15. Nickel with dime in the same cycle -> reject.
- Nickel only (credit 1), select 0010 -> ignored, state ACCUM. Select 0011 at credit 5 -> ignored. Coin during VEND -> reject_o, credit unchanged.
- rst_ni low mid-CHANGE (credit 7) -> all outputs 0 immediately, IDLE, credit 0. A quarter after release -> credit 5.
